// File: rtl/cal_mon_pkg.sv
// Shared definitions for the calibration pulse monitor: FSM encoding,
// readout select codes, the triplicable core state record and helpers.
package cal_mon_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StArmed  = 2'b01,
        StTiming = 2'b10
    } cal_state_e;

    localparam logic [1:0] RdSelHit      = 2'd0;
    localparam logic [1:0] RdSelTmoStray = 2'd1;
    localparam logic [1:0] RdSelOvlLat   = 2'd2;
    localparam logic [1:0] RdSelStatus   = 2'd3;

    localparam int unsigned DefMaxLat = 255;

    // Everything that is triplicated when TMR is enabled lives in this record.
    typedef struct packed {
        cal_state_e  state;
        logic [7:0]  timer;
        logic [1:0]  src;
        logic [11:0] hit;
        logic [7:0]  tmo;
        logic [7:0]  stray;
        logic [7:0]  ovl;
        logic [7:0]  latency;
    } cal_core_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Bitwise 2-of-3 majority over the whole record.
    function automatic cal_core_t vote3(input cal_core_t a, input cal_core_t b,
                                        input cal_core_t c);
        return cal_core_t'((a & b) | (a & c) | (b & c));
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level followed by a
// rising-edge detector on the synchronized signal.
module sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_prev;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta      <= 1'b0;
            r_sync      <= 1'b0;
            r_sync_prev <= 1'b0;
        end else begin
            r_meta      <= i_async;
            r_sync      <= r_meta;
            r_sync_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_sync_prev;

endmodule

// File: rtl/cal_pulse_mon.sv
// Calibration pulse monitor: measures the latency from a pulse-count change
// to the returning trigger, and keeps hit/timeout/stray/overlap statistics
// with a request/acknowledge register readout.
module cal_pulse_mon
    import cal_mon_pkg::*;
#(
    parameter int unsigned TMR     = 0,
    parameter int unsigned MAX_LAT = DefMaxLat
) (
    input  logic        CLK40,
    input  logic        RST_RESYNC,
    input  logic [11:0] INJPLSCNT,
    input  logic [11:0] EXTPLSCNT,
    input  logic        TRG_PULSE,
    input  logic        MEAS_EN,
    input  logic        CLR_STATS,
    input  logic [1:0]  RD_SEL,
    input  logic        RD_REQ,
    output logic        RD_ACK,
    output logic [15:0] RD_DATA,
    output logic        LAT_VLD,
    output logic [7:0]  LATENCY
);

    localparam logic [7:0] MaxLatC = 8'(MAX_LAT);

    logic        w_trg_edge;
    logic [11:0] r_inj_prev;
    logic [11:0] r_ext_prev;
    logic        r_prev_vld;
    logic [1:0]  w_src;
    logic        w_evt;
    cal_core_t   w_core_q;
    cal_core_t   w_core_d;
    logic        w_lat_vld_d;
    logic        r_lat_vld;
    logic        r_rd_req_prev;
    logic        r_rd_ack;
    logic [15:0] r_rd_data;
    logic [15:0] w_rd_mux;

    sync_edge u_trg_sync (
        .i_clk   (CLK40),
        .i_rst   (RST_RESYNC),
        .i_async (TRG_PULSE),
        .o_rise  (w_trg_edge)
    );

    // Previous pulse counts; r_prev_vld masks the compare in the first cycle after reset.
    always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            r_inj_prev <= '0;
            r_ext_prev <= '0;
            r_prev_vld <= 1'b0;
        end else begin
            r_inj_prev <= INJPLSCNT;
            r_ext_prev <= EXTPLSCNT;
            r_prev_vld <= 1'b1;
        end
    end

    assign w_src = {r_prev_vld & (EXTPLSCNT != r_ext_prev),
                    r_prev_vld & (INJPLSCNT != r_inj_prev)};
    assign w_evt = |w_src;

    // Core state storage: three voted copies or a single copy.
    if (TMR != 0) begin : g_tmr
        (* keep = "true", dont_touch = "true" *) cal_core_t r_core [3];

        // Each copy loads the same next state computed from the voted value.
        always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
            if (RST_RESYNC) begin
                for (int i = 0; i < 3; i++) begin
                    r_core[i] <= '0;
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    r_core[i] <= w_core_d;
                end
            end
        end

        assign w_core_q = vote3(r_core[0], r_core[1], r_core[2]);
    end else begin : g_single
        cal_core_t r_core;

        // Single unprotected copy of the core state.
        always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
            if (RST_RESYNC) begin
                r_core <= '0;
            end else begin
                r_core <= w_core_d;
            end
        end

        assign w_core_q = r_core;
    end

    // Measurement FSM next state, timer and statistics updates.
    always_comb begin
        w_core_d    = w_core_q;
        w_lat_vld_d = 1'b0;
        if (!MEAS_EN) begin
            w_core_d.state = StIdle;
            w_core_d.timer = '0;
        end else begin
            unique case (w_core_q.state)
                StIdle: begin
                    w_core_d.state = StArmed;
                    w_core_d.timer = '0;
                end
                StArmed: begin
                    // A coincident trigger cannot belong to this pulse: count it stray.
                    if (w_trg_edge) begin
                        w_core_d.stray = sat_inc8(w_core_q.stray);
                    end
                    if (w_evt) begin
                        w_core_d.timer = '0;
                        w_core_d.src   = w_src;
                        w_core_d.state = StTiming;
                    end
                end
                StTiming: begin
                    if (w_trg_edge) begin
                        w_core_d.latency = w_core_q.timer;
                        w_core_d.hit     = w_core_q.hit + 12'd1;
                        w_lat_vld_d      = 1'b1;
                    end
                    if (w_evt) begin
                        if (!w_trg_edge) begin
                            w_core_d.ovl = sat_inc8(w_core_q.ovl);
                        end
                        w_core_d.timer = '0;
                        w_core_d.src   = w_src;
                    end else if (w_trg_edge) begin
                        w_core_d.timer = '0;
                        w_core_d.state = StArmed;
                    end else if (w_core_q.timer == MaxLatC) begin
                        w_core_d.tmo   = sat_inc8(w_core_q.tmo);
                        w_core_d.timer = '0;
                        w_core_d.state = StArmed;
                    end else begin
                        w_core_d.timer = w_core_q.timer + 8'd1;
                    end
                end
                default: begin
                    w_core_d.state = StIdle;
                    w_core_d.timer = '0;
                end
            endcase
        end
        // Clearing wins over any same-cycle increment and suppresses the strobe.
        if (CLR_STATS) begin
            w_core_d.hit     = '0;
            w_core_d.tmo     = '0;
            w_core_d.stray   = '0;
            w_core_d.ovl     = '0;
            w_core_d.latency = '0;
            w_lat_vld_d      = 1'b0;
        end
    end

    // Latency-valid strobe register.
    always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            r_lat_vld <= 1'b0;
        end else begin
            r_lat_vld <= w_lat_vld_d;
        end
    end

    // Readout register select.
    always_comb begin
        w_rd_mux = '0;
        case (RD_SEL)
            RdSelHit:      w_rd_mux = {4'h0, w_core_q.hit};
            RdSelTmoStray: w_rd_mux = {w_core_q.tmo, w_core_q.stray};
            RdSelOvlLat:   w_rd_mux = {w_core_q.ovl, w_core_q.latency};
            RdSelStatus:   w_rd_mux = {w_core_q.state, w_core_q.src, 12'h000};
            default:       w_rd_mux = '0;
        endcase
    end

    // Readout handshake: capture on request rise, hold until the request drops.
    always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            r_rd_req_prev <= 1'b0;
            r_rd_ack      <= 1'b0;
            r_rd_data     <= '0;
        end else begin
            r_rd_req_prev <= RD_REQ;
            if (RD_REQ && !r_rd_req_prev) begin
                r_rd_ack  <= 1'b1;
                r_rd_data <= w_rd_mux;
            end else if (!RD_REQ) begin
                r_rd_ack <= 1'b0;
            end
        end
    end

    assign RD_ACK  = r_rd_ack;
    assign RD_DATA = r_rd_data;
    assign LAT_VLD = r_lat_vld;
    assign LATENCY = w_core_q.latency;

endmodule
